// File: rtl/tlb_ptw.sv
// tlb_ptw: single-outstanding radix page-table walker feeding the TLB fill path.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             miss request handshake
//   req_va, req_pcid                missing virtual address and its pcid
//   root_base                       root table base, sampled at acceptance (low SPAGE bits ignored)
//   mem_req_valid/mem_req_ready     PTE read request handshake, mem_addr is the PTE address
//   mem_resp_valid, mem_resp_data   PTE read data (taken only while waiting for it)
//   resp_valid/resp_ready           walk result handshake
//   resp_pa, resp_pcid, resp_fault  translated address (0 on fault), pcid, fault flag
module tlb_ptw #(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SPCID  = 12,
  parameter int LEVELS = 3,
  parameter int VPN_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SADDR-1:0] req_va,
  input  logic [SPCID-1:0] req_pcid,
  input  logic [SADDR-1:0] root_base,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [SADDR-1:0] mem_addr,
  input  logic             mem_resp_valid,
  input  logic [SADDR-1:0] mem_resp_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [SADDR-1:0] resp_pa,
  output logic [SPCID-1:0] resp_pcid,
  output logic             resp_fault
);
  localparam int VAW = SPAGE + LEVELS * VPN_W;
  localparam int LW = LEVELS > 1 ? $clog2(LEVELS) : 1;
  localparam logic [SADDR-1:0] OFS_MASK = (SADDR'(1) << SPAGE) - SADDR'(1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, FAULT} state_t;
  state_t state, state_nx;
  logic [LW-1:0] level;
  logic [SADDR-1:0] va_q, base_q, pa_q, kmask, leaf_pa;
  logic [SPCID-1:0] pcid_q;
  logic [VPN_W-1:0] vpn;
  logic last, misaligned;
  // kmask covers the bits a leaf at the current level maps straight from the VA
  always_comb begin
    vpn = '0;
    kmask = OFS_MASK;
    for (int i = 0; i < LEVELS; i++)
      if (level == LW'(i)) begin
        vpn = va_q[SPAGE+(LEVELS-i)*VPN_W-1 -: VPN_W];
        kmask = (SADDR'(1) << (SPAGE + (LEVELS-1-i)*VPN_W)) - SADDR'(1);
      end
  end
  assign last = level == LW'(LEVELS-1);
  assign misaligned = |(mem_resp_data & kmask & ~OFS_MASK);
  assign leaf_pa = (mem_resp_data & ~kmask) | (va_q & kmask);
  assign mem_addr = state == ISSUE ? base_q + SADDR'({vpn, 3'b000}) : '0;
  assign req_ready = state == IDLE;
  assign mem_req_valid = state == ISSUE;
  assign resp_valid = state == DONE || state == FAULT;
  assign resp_fault = state == FAULT;
  assign resp_pa = state == DONE ? pa_q : '0;
  assign resp_pcid = pcid_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = |(req_va >> VAW) ? FAULT : ISSUE;
      ISSUE:   if (mem_req_ready) state_nx = WAIT;
      WAIT:    if (mem_resp_valid)
                 state_nx = !mem_resp_data[0] ? FAULT :
                            !mem_resp_data[1] ? (last ? FAULT : ISSUE) :
                            misaligned ? FAULT : DONE;
      default: if (resp_ready) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
      va_q <= '0;
      base_q <= '0;
      pa_q <= '0;
      pcid_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        va_q <= req_va;
        pcid_q <= req_pcid;
        base_q <= root_base & ~OFS_MASK;
        level <= '0;
      end
      if (state == WAIT && mem_resp_valid) begin
        pa_q <= leaf_pa;
        if (state_nx == ISSUE) begin
          base_q <= mem_resp_data & ~OFS_MASK;
          level <= level + LW'(1);
        end
      end
    end
endmodule

// File: tb/tb_tlb_ptw.sv
// tb_tlb_ptw: directed and randomized walks against a sparse memory and a reference walker.
module tb_tlb_ptw;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, mem_req_valid, mem_req_ready = 0;
  logic mem_resp_valid = 0, resp_valid, resp_ready = 0, resp_fault;
  logic [63:0] req_va = 0, root_base = 0, mem_addr, mem_resp_data = 0, resp_pa;
  logic [11:0] req_pcid = 0, resp_pcid;
  always #5 clk = ~clk;

  tlb_ptw dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_va(req_va), .req_pcid(req_pcid), .root_base(root_base),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pa(resp_pa),
    .resp_pcid(resp_pcid), .resp_fault(resp_fault)
  );

  logic [63:0] mem [logic [63:0]];
  logic [63:0] seen_addr[$], exp_addr[$];
  logic [63:0] pend_a, held_addr, obs_pa;
  logic pend = 0;
  int stall_cfg = 0, stall_cnt = 0, obs_lat;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // One cycle: advance to the next falling edge, then act as a zero-wait memory
  // (optionally stalling each request stall_cfg cycles) for the coming rising edge.
  task automatic tick();
    @(negedge clk);
    mem_resp_valid = 0;
    if (pend) begin
      mem_resp_valid = 1;
      mem_resp_data = rd(pend_a);
      pend = 0;
    end
    mem_req_ready = 0;
    if (mem_req_valid) begin
      if (stall_cnt > 0) begin
        if (stall_cnt == stall_cfg) held_addr = mem_addr;
        else chk("mem_addr_hold", mem_addr, held_addr);
        stall_cnt--;
      end else begin
        if (stall_cfg > 0) chk("mem_addr_hold", mem_addr, held_addr);
        mem_req_ready = 1;
        pend = 1;
        pend_a = mem_addr;
        seen_addr.push_back(mem_addr);
        stall_cnt = stall_cfg;
      end
    end
  endtask

  // Reference walker: follows the radix table with plain arithmetic.
  task automatic model(input logic [63:0] va, input logic [63:0] root,
                       output logic [63:0] pa, output logic flt);
    logic [63:0] base, pte, size;
    base = root & ~64'hfff;
    exp_addr = {};
    pa = 0;
    flt = 1;
    if ((va >> 39) != 0) return;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(base + ((va >> (12 + 9 * (2 - i))) % 512) * 8);
      pte = rd(exp_addr[i]);
      if (pte[0] == 0) return;
      if (pte[1]) begin
        size = 64'd1 << (12 + 9 * (2 - i));
        if (((pte % size) >> 12) != 0) return;
        pa = pte - pte % size + va % size;
        flt = 0;
        return;
      end
      base = pte & ~64'hfff;
    end
  endtask

  task automatic walk(input logic [63:0] va, input logic [63:0] root, input logic [11:0] pcid,
                      input int mst, input int rwait, input bit hold_next,
                      input logic [63:0] nva, input logic [63:0] nroot, input logic [11:0] npcid);
    logic [63:0] epa;
    logic eflt;
    int lat;
    model(va, root, epa, eflt);
    req_va = va;
    req_pcid = pcid;
    root_base = root;
    req_valid = 1;
    stall_cfg = mst;
    stall_cnt = mst;
    seen_addr = {};
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    tick();
    req_valid = 0;
    root_base = {$urandom, $urandom};
    lat = 1;
    while (!resp_valid && lat < 300) begin
      tick();
      lat++;
    end
    obs_lat = lat;
    obs_pa = resp_pa;
    chk("latency", 64'(lat), 64'(1 + exp_addr.size() * (2 + mst)));
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("n_reads", 64'(seen_addr.size()), 64'(exp_addr.size()));
    foreach (exp_addr[i]) if (i < seen_addr.size()) chk("pte_addr", seen_addr[i], exp_addr[i]);
    chk("resp_pa", resp_pa, epa);
    chk("resp_fault", 64'(resp_fault), 64'(eflt));
    chk("resp_pcid", 64'(resp_pcid), 64'(pcid));
    if (hold_next) begin
      req_valid = 1;
      req_va = nva;
      req_pcid = npcid;
      root_base = nroot;
    end
    for (int k = 0; k < rwait; k++) begin
      tick();
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_pa", resp_pa, epa);
      chk("hold_fault", 64'(resp_fault), 64'(eflt));
      chk("hold_pcid", 64'(resp_pcid), 64'(pcid));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    chk("released_valid", 64'(resp_valid), 64'd0);
    chk("released_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic std_table();
    mem.delete();
    mem[64'h1800] = 64'h2001;
    mem[64'h2808] = 64'h3001;
    mem[64'h3828] = 64'h8_7654_3003;
  endtask

  localparam logic [63:0] VA0 = 64'h40_2030_5ABC;

  initial begin
    logic [63:0] va, root, base, a, pte, size;
    int r;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_fault", 64'(resp_fault), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_resp_pa", resp_pa, 64'd0);
    chk("rst_resp_pcid", 64'(resp_pcid), 64'd0);
    rst_n = 1;
    tick();

    std_table();
    walk(VA0, 64'h1000, 12'h05, 0, 0, 0, 0, 0, 0);
    chk("full_pa", obs_pa, 64'h8_7654_3ABC);
    chk("full_lat", 64'(obs_lat), 64'd7);
    mem[64'h2808] = 64'h4020_0003;
    walk(VA0, 64'h1000, 12'h06, 0, 0, 0, 0, 0, 0);
    chk("super_pa", obs_pa, 64'h4030_5ABC);
    chk("super_lat", 64'(obs_lat), 64'd5);
    mem[64'h1800] = 64'h0;
    walk(VA0, 64'h1000, 12'h07, 0, 0, 0, 0, 0, 0);
    chk("root_fault_lat", 64'(obs_lat), 64'd3);
    std_table();
    mem[64'h2808] = 64'h4020_1003;
    walk(VA0, 64'h1000, 12'h08, 0, 0, 0, 0, 0, 0);
    std_table();
    mem[64'h3828] = 64'h3001;
    walk(VA0, 64'h1000, 12'h09, 0, 0, 0, 0, 0, 0);
    walk(64'h8000_0000_0000_0000, 64'h1000, 12'h0a, 0, 0, 0, 0, 0, 0);
    chk("noncanon_lat", 64'(obs_lat), 64'd1);

    std_table();
    walk(VA0, 64'h1000, 12'h0b, 4, 5, 1, VA0, 64'h1000, 12'h0c);
    walk(VA0, 64'h1000, 12'h0c, 0, 0, 0, 0, 0, 0);

    req_va = VA0;
    req_pcid = 12'h0d;
    root_base = 64'h1000;
    stall_cfg = 0;
    stall_cnt = 0;
    req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_mem_addr", mem_addr, 64'd0);
    chk("mid_rst_resp_pcid", 64'(resp_pcid), 64'd0);
    @(negedge clk);
    rst_n = 1;
    pend = 0;
    mem_resp_valid = 1;
    mem_resp_data = 64'h3001;
    @(negedge clk);
    mem_resp_valid = 0;
    chk("late_resp_req_ready", 64'(req_ready), 64'd1);
    chk("late_resp_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("late_resp_resp_valid", 64'(resp_valid), 64'd0);
    walk(VA0, 64'h1000, 12'h0e, 0, 0, 0, 0, 0, 0);
    chk("after_rst_pa", obs_pa, 64'h8_7654_3ABC);

    repeat (30) begin
      va = {$urandom, $urandom} & ((64'd1 << 39) - 1);
      if ($urandom_range(0, 7) == 0) va[63 - $urandom_range(0, 24)] = 1'b1;
      root = {32'h0, $urandom} & ~64'hfff;
      mem.delete();
      base = root;
      for (int i = 0; i < 3; i++) begin
        a = base + ((va >> (12 + 9 * (2 - i))) % 512) * 8;
        size = 64'd1 << (12 + 9 * (2 - i));
        r = $urandom_range(0, 7);
        if (r == 0) pte = {$urandom, $urandom} & ~64'h1;
        else if (r <= 3 || (i == 2 && r < 7)) begin
          pte = ({$urandom, $urandom} & ~(size - 1)) | 64'h3;
          if (r == 1 && i < 2) pte = pte | 64'h1000;
        end else pte = ({32'h0, $urandom} & ~64'hfff) | 64'h1;
        mem[a] = pte;
        if (pte[1] || !pte[0]) break;
        base = pte & ~64'hfff;
      end
      walk(va, root, 12'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlb_ptw.md
Name: tlb_ptw

Overview:
Hardware page-table walker directly downstream of the TLB cache. On a TLB miss it walks an LEVELS-deep radix page table through a single-outstanding memory read port. It returns the translated physical address, which the TLB uses as its fill `pa`, or a fault flag. One walk at a time; new requests are blocked with valid/ready until the current walk's response is consumed.

Parameters:
SADDR, 64, address and PTE width in bits
SPAGE, 12, page offset width (4 KiB page)
SPCID, 12, process-context identifier width
LEVELS, 3, page-table levels (index 0 = root)
VPN_W, 9, VA bits consumed per level; PTE size fixed at 8 bytes; requires SPAGE+LEVELS*VPN_W <= SADDR

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  miss request valid
req_ready  out  1  walker can accept a request
req_va  in  SADDR  missing virtual address
req_pcid  in  SPCID  pcid of request
root_base  in  SADDR  root table physical base, sampled at request acceptance, low SPAGE bits ignored
mem_req_valid  out  1  PTE read request valid
mem_req_ready  in  1  memory accepts read
mem_addr  out  SADDR  8-byte-aligned PTE address
mem_resp_valid  in  1  PTE data valid
mem_resp_data  in  SADDR  PTE
resp_valid  out  1  walk result valid
resp_ready  in  1  consumer accepts result
resp_pa  out  SADDR  translated address (full, offset included); 0 on fault
resp_pcid  out  SPCID  pcid of the walk
resp_fault  out  1  translation fault

Behaviour:
- Reset (async, any state): state IDLE. req_ready=1. mem_req_valid=0, resp_valid=0, resp_fault=0. mem_addr=0, resp_pa=0, resp_pcid=0. Level counter=0. Any walk in flight is dropped. A memory response arriving after reset is ignored.
- PTE format:
  - bit0 V (valid), bit1 L (leaf).
  - bits[SADDR-1:SPAGE] PPN field; the next table or page base is {pte[SADDR-1:SPAGE], SPAGE'b0}. Other bits are ignored.
- VPN for level i: va[SPAGE+(LEVELS-i)*VPN_W-1 -: VPN_W].
- PTE address: base + {vpn_i, 3'b000}, SADDR-bit wrap.
- States:
  - IDLE: req_ready=1. On req_valid, latch va, pcid and root_base as base, set level=0.
    - If va[SADDR-1:SPAGE+LEVELS*VPN_W] != 0 (non-canonical) -> FAULT.
    - Else -> ISSUE.
  - ISSUE: mem_req_valid=1, mem_addr stable. Stay until mem_req_ready -> WAIT.
  - WAIT: mem_req_valid=0. On mem_resp_valid, evaluate the PTE:
    - V=0 -> FAULT.
    - V=1, L=0, level<LEVELS-1 -> base=PTE page base, level+1 -> ISSUE.
    - V=1, L=0, level==LEVELS-1 -> FAULT.
    - V=1, L=1: superpage size bits K=SPAGE+(LEVELS-1-level)*VPN_W.
      - If pte[K-1:SPAGE] != 0 (misaligned) -> FAULT.
      - Else resp_pa = {pte[SADDR-1:K], va[K-1:0]} -> DONE.
  - DONE / FAULT: resp_valid=1. resp_fault=1 only in FAULT, with resp_pa=0. resp_pcid=latched pcid. Outputs held stable until resp_ready, then -> IDLE.
- req_ready=0 outside IDLE. mem_resp_valid outside WAIT is ignored.
- Latency, request accepted in cycle T, zero-wait memory (accept in ISSUE, response the next cycle): resp_valid first high in cycle T+1+2*(levels walked).
- Non-canonical fault: resp_valid high in T+1 with no memory access.
- resp_valid && resp_ready in the same cycle as a new req_valid: the new request is not accepted until the following cycle (IDLE).

Test Plan:
- Full 3-level walk:
  - Setup: root_base=0x1000, req_va=0x40_2030_5ABC, pcid=0x05. Memory: [0x1800]=0x2001, [0x2808]=0x3001, [0x3828]=0x8_7654_3003.
  - Required: mem_addr sequence 0x1800, 0x2808, 0x3828. resp_pa=0x8_7654_3ABC, resp_fault=0, resp_pcid=0x05, resp_valid at T+7.
- 2 MiB superpage: same VA with [0x2808]=0x4020_0003 -> two reads, resp_pa=0x4030_5ABC, resp_valid at T+5.
- Faults, each with resp_fault=1 and resp_pa=0:
  - [0x1800]=0x0 -> fault at T+3.
  - [0x2808]=0x4020_1003 (misaligned) -> fault.
  - Level-2 PTE=0x3001 (non-leaf at last level) -> fault.
- Non-canonical req_va=0x8000_0000_0000_0000 -> resp_fault=1 at T+1, mem_req_valid never asserted.
- Backpressure:
  - mem_req_ready low 4 cycles -> mem_req_valid and mem_addr held stable.
  - resp_ready low 5 cycles -> resp_* held and req_ready=0.
  - Second req_valid held throughout -> accepted only after the response handshake.
- Reset mid-walk: rst_n low while in WAIT -> all outputs at reset values immediately. A late mem_resp_valid is ignored. The next request walks correctly from level 0.
